// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and constants for the ALU divider
package alu_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/seq_div4_div_step.sv
// div_step: one restoring compare-subtract step of the divider
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             nb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;
  always_comb begin
    t = {r, nb};
    diff = t - {1'b0, d};
    q_bit = ~diff[WIDTH];
    r_out = diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_div4.sv
// seq_div4: sequential unsigned restoring divider, one quotient bit per clock
module seq_div4
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] r, q, d, r_nxt;
  logic [CW-1:0] count;
  logic q_bit, accept;
  assign accept = start && !done;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r(r),
    .nb(q[WIDTH-1]),
    .d(d),
    .r_out(r_nxt),
    .q_bit(q_bit)
  );
  // done trails the DONE state by one edge; a request in that cycle is refused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      r <= '0;
      q <= '0;
      d <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= accept;
          if (accept) begin
            if (divisor == '0) begin
              quotient <= DIV_ZERO_Q;
              remainder <= dividend;
              div_by_zero <= 1'b1;
              state <= DONE;
            end else begin
              r <= '0;
              q <= dividend;
              d <= divisor;
              count <= '0;
              div_by_zero <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          r <= r_nxt;
          q <= {q[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            quotient <= {q[WIDTH-2:0], q_bit};
            remainder <= r_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div4.sv
// tb_seq_div4: directed and sweep checks of the sequential divider
module tb_seq_div4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  int checks = 0;
  int failures = 0;
  seq_div4 #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] a, input logic [3:0] b, output int lat, output logic b1);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b1 = busy;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] eq, input logic [3:0] er, input logic ez, input int el);
    int lat;
    logic b1;
    run(a, b, lat, b1);
    chk({tag, "_busy"}, b1, 1);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, div_by_zero, ez);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask
  initial begin
    int lat, pulses;
    logic b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    op("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 6);
    chk("d13_3_idle", busy, 0);
    op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 6);
    op("d7_9", 4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 6);
    op("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 6);
    op("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 6);
    op("d9_0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 2);
    op("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 6);
    // re-pulse start with new operands while CALC and while DONE
    @(negedge clk);
    dividend = 4'd13;
    divisor = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 1; i < 14; i++) begin
      if (i == 2 || i == 5) begin
        dividend = 4'd6;
        divisor = 4'd2;
        start = 1'b1;
      end else start = 1'b0;
      if (done) begin
        pulses++;
        chk("ign_lat", i, 6);
        chk("ign_q", quotient, 4'd4);
        chk("ign_r", remainder, 4'd1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_pulses", pulses, 1);
    chk("ign_hold_q", quotient, 4'd4);
    // async reset between edges mid-CALC
    @(negedge clk);
    dividend = 4'd13;
    divisor = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_z", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("arst_nodone", pulses, 0);
    op("d10_4", 4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 6);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run(4'(a), 4'(b), lat, b1);
        if (b == 0) begin
          chk("sw_lat", lat, 2);
          chk("sw_q", quotient, 4'hF);
          chk("sw_r", remainder, a);
          chk("sw_z", div_by_zero, 1);
        end else begin
          chk("sw_lat", lat, 6);
          chk("sw_q", quotient, a / b);
          chk("sw_r", remainder, a % b);
          chk("sw_z", div_by_zero, 0);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
